// File: rtl/usb_ctrl_regs_tx.sv
// Streams ctrl-regs frames from the register reader onto an FT245-sync write port.
// A small byte buffer decouples the 3-cycle reader handshake from FTDI back-pressure.
module usb_ctrl_regs_tx #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned FRAME_BYTES = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       usb_tx_start,
    output logic       rdreq,
    input  logic [7:0] q,
    input  logic       last_byte,
    input  logic       ft_txe_n,
    output logic       ft_wr_n,
    output logic [7:0] ft_data,
    output logic       ft_siwu_n,
    output logic       busy,
    output logic       frame_done,
    output logic       len_err,
    output logic [4:0] byte_cnt
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {IDLE, CAP0, REQ, WAIT1, WAIT2, DRAIN, SIWU} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          lb;
    logic          push, pop, accept, out_full, rdreq_nxt;

    // Output register is full exactly while the write strobe is asserted.
    assign out_full = ~ft_wr_n;
    assign accept   = out_full & ~ft_txe_n;
    assign push     = (state == CAP0) || (state == WAIT2);
    assign pop      = (count != '0) && (~out_full || accept);

    // Next state, buffer occupancy and the read request for the coming cycle.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        rdreq_nxt = 1'b0;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
        case (state)
            IDLE:    if (usb_tx_start) state_nxt = CAP0;
            CAP0:    state_nxt = REQ;
            REQ:     if (rdreq) state_nxt = WAIT1;
            WAIT1:   state_nxt = WAIT2;
            WAIT2:   state_nxt = (lb && !usb_tx_start) ? DRAIN : REQ;
            DRAIN:   if ((count == '0) && !out_full) state_nxt = SIWU;
            SIWU:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Registered rdreq is high in REQ only while the buffer has room.
        rdreq_nxt = (state_nxt == REQ) && (count_nxt < CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rdreq      <= 1'b0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            lb         <= 1'b0;
            ft_wr_n    <= 1'b1;
            ft_data    <= 8'd0;
            ft_siwu_n  <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            len_err    <= 1'b0;
            byte_cnt   <= 5'd0;
        end else begin
            state      <= state_nxt;
            rdreq      <= rdreq_nxt;
            count      <= count_nxt;
            busy       <= (state_nxt != IDLE);
            frame_done <= (state_nxt == SIWU);
            ft_siwu_n  <= (state_nxt != SIWU);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (state == WAIT1) lb <= last_byte;
            if (pop) begin
                ft_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
                ft_wr_n <= 1'b0;
            end else if (accept) begin
                ft_wr_n <= 1'b1;
            end
            if (state == CAP0) begin
                byte_cnt <= 5'd0;
                len_err  <= 1'b0;
            end else begin
                if (accept && (byte_cnt != 5'd31)) byte_cnt <= byte_cnt + 5'd1;
                if ((state_nxt == SIWU) && (byte_cnt != 5'(FRAME_BYTES))) len_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_usb_ctrl_regs_tx.sv
// Self-checking bench for usb_ctrl_regs_tx: reader model, FTDI back-pressure
// patterns and a byte-order scoreboard per frame.
module tb_usb_ctrl_regs_tx;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 22;
    localparam int unsigned NV    = 10;

    typedef struct {
        int unsigned n_bytes;
        int unsigned txe_mode;    // 0 open, 1 toggle, 2 stall after byte 5, 3 random
        bit          b2b;         // next frame requested before this one finishes
        int unsigned exp_cnt;
        bit          exp_len_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       usb_tx_start;
    logic       rdreq;
    logic [7:0] q;
    logic       last_byte;
    logic       ft_txe_n;
    logic       ft_wr_n;
    logic [7:0] ft_data;
    logic       ft_siwu_n;
    logic       busy;
    logic       frame_done;
    logic       len_err;
    logic [4:0] byte_cnt;

    int          checks = 0;
    int          failures = 0;
    int unsigned cur_n, rd_n, nxt_n, rd_ptr, acc_idx, fd_cnt, sw_cnt, txe_mode, stall_left, rd_age;
    int          fin_cnt;
    logic [7:0]  cur_off, rd_off, nxt_off, prev_data;
    bit          rd_pend, b2b, stall_done, prev_hold;

    usb_ctrl_regs_tx #(.FIFO_DEPTH(DEPTH), .FRAME_BYTES(FRAME)) dut (
        .clk(clk), .rst(rst), .usb_tx_start(usb_tx_start), .rdreq(rdreq), .q(q),
        .last_byte(last_byte), .ft_txe_n(ft_txe_n), .ft_wr_n(ft_wr_n), .ft_data(ft_data),
        .ft_siwu_n(ft_siwu_n), .busy(busy), .frame_done(frame_done), .len_err(len_err),
        .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] fbyte(input logic [7:0] off, input int unsigned i);
        return off + 8'(i);
    endfunction

    function automatic logic is_last(input int unsigned i, input int unsigned n);
        return (i == 10) || (i == 15) || (i == 21) || (i == n - 1);
    endfunction

    task automatic reader_init(input int unsigned n, input logic [7:0] off);
        rd_n = n; rd_off = off; rd_ptr = 0; rd_pend = 0; rd_age = 100; fin_cnt = -1;
        q = fbyte(off, 0);
        last_byte = 1'b0;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_rdreq"},      32'(rdreq), 32'd0);
        chk({tag, "_ft_wr_n"},    32'(ft_wr_n), 32'd1);
        chk({tag, "_ft_siwu_n"},  32'(ft_siwu_n), 32'd1);
        chk({tag, "_ft_data"},    32'(ft_data), 32'd0);
        chk({tag, "_busy"},       32'(busy), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_len_err"},    32'(len_err), 32'd0);
        chk({tag, "_byte_cnt"},   32'(byte_cnt), 32'd0);
    endtask

    // One cycle: plan ft_txe_n, score acceptances, then play the reader's part.
    task automatic tick();
        @(negedge clk);
        if (prev_hold) begin
            chk("hold_wr_n", 32'(ft_wr_n), 32'd0);
            chk("hold_data", 32'(ft_data), 32'(prev_data));
        end
        case (txe_mode)
            0: ft_txe_n = 1'b0;
            1: ft_txe_n = ~ft_txe_n;
            2: begin
                if (stall_left > 0) begin
                    ft_txe_n = 1'b1;
                    stall_left--;
                    if (stall_left == 0) begin
                        chk("stall_data", 32'(ft_data), 32'(fbyte(cur_off, 6)));
                        chk("stall_wr_n", 32'(ft_wr_n), 32'd0);
                    end
                end else begin
                    ft_txe_n = 1'b0;
                end
            end
            default: ft_txe_n = ($urandom_range(0, 2) == 0);
        endcase
        if (!ft_wr_n && !ft_txe_n) begin
            chk("accept_in_frame", 32'(acc_idx < cur_n), 32'd1);
            if (acc_idx < cur_n) chk("accept_data", 32'(ft_data), 32'(fbyte(cur_off, acc_idx)));
            if (txe_mode == 2 && !stall_done && acc_idx == 5) begin
                stall_left = 12;
                stall_done = 1'b1;
            end
            acc_idx++;
        end
        if (frame_done) fd_cnt++;
        if (!ft_siwu_n) sw_cnt++;
        rd_age++;
        if (fin_cnt >= 0) begin
            fin_cnt++;
            if (fin_cnt == 3 && b2b) usb_tx_start = 1'b1;
        end
        if (rd_pend) begin
            q = fbyte(rd_off, rd_ptr);
            rd_pend = 1'b0;
        end
        if (rdreq) begin
            chk("rdreq_legal", 32'((rd_age >= 3) && (rd_ptr + 1 < rd_n)), 32'd1);
            rd_age = 0;
            rd_ptr++;
            last_byte = is_last(rd_ptr, rd_n);
            rd_pend = 1'b1;
            if (rd_ptr == rd_n - 1) begin
                usb_tx_start = 1'b0;
                fin_cnt = 0;
            end
        end
        prev_hold = !ft_wr_n && ft_txe_n;
        prev_data = ft_data;
    endtask

    task automatic run_frame(input vec_t v, input logic [7:0] off, input bit started);
        int unsigned t;
        bit got;
        cur_n = v.n_bytes; cur_off = off; acc_idx = 0; fd_cnt = 0; sw_cnt = 0;
        txe_mode = v.txe_mode; stall_left = 0; stall_done = 1'b0; b2b = v.b2b;
        if (!started) begin
            reader_init(v.n_bytes, off);
            usb_tx_start = 1'b1;
        end
        got = 1'b0;
        t = 0;
        while (!got && t < 1000) begin
            tick();
            t++;
            if (t == 1 && started) chk("cap0_busy", 32'(busy), 32'd1);
            if (t == 2) begin
                chk("start_byte_cnt", 32'(byte_cnt), 32'd0);
                chk("start_len_err", 32'(len_err), 32'd0);
            end
            if (frame_done) begin
                got = 1'b1;
                chk("byte_cnt", 32'(byte_cnt), 32'(v.exp_cnt));
                chk("len_err", 32'(len_err), 32'(v.exp_len_err));
                chk("delivered", 32'(acc_idx), 32'(v.n_bytes));
                if (v.b2b) reader_init(nxt_n, nxt_off);
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout: no frame_done after %0d cycles (n=%0d)", t, v.n_bytes);
        end
        tick();
        chk("post_frame_done", 32'(frame_done), 32'd0);
        chk("post_siwu_n", 32'(ft_siwu_n), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_len_err", 32'(len_err), 32'(v.exp_len_err));
        chk("frame_done_pulses", 32'(fd_cnt), 32'd1);
        chk("siwu_low_cycles", 32'(sw_cnt), 32'd1);
    endtask

    task automatic reset_mid_frame();
        int unsigned t;
        vec_t v;
        cur_n = FRAME; cur_off = 8'h40; acc_idx = 0; txe_mode = 0; b2b = 1'b0;
        stall_left = 0; stall_done = 1'b0;
        reader_init(FRAME, 8'h40);
        usb_tx_start = 1'b1;
        t = 0;
        while (byte_cnt != 5'd7 && t < 500) begin
            tick();
            t++;
        end
        chk("reach_cnt7", 32'(byte_cnt), 32'd7);
        rst = 1'b1;
        #1;
        reset_vals("midrst");
        prev_hold = 1'b0;
        reader_init(FRAME, 8'h80);
        usb_tx_start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        v = '{FRAME, 0, 1'b0, FRAME, 1'b0};
        run_frame(v, 8'h80, 1'b1);
    endtask

    initial begin
        vec_t       tbl [NV];
        logic [7:0] offs [NV];
        vec_t       v;
        bit         started;
        int unsigned n;

        tbl[0] = '{22, 0, 1'b0, 22, 1'b0};
        tbl[1] = '{22, 2, 1'b0, 22, 1'b0};
        tbl[2] = '{22, 1, 1'b0, 22, 1'b0};
        tbl[3] = '{11, 0, 1'b0, 11, 1'b1};
        tbl[4] = '{11, 3, 1'b1, 11, 1'b1};
        tbl[5] = '{22, 3, 1'b0, 22, 1'b0};
        tbl[6] = '{35, 0, 1'b0, 31, 1'b1};
        tbl[7] = '{2,  3, 1'b0, 2,  1'b1};
        tbl[8] = '{31, 1, 1'b0, 31, 1'b1};
        tbl[9] = '{16, 3, 1'b0, 16, 1'b1};
        offs[0] = 8'h00;
        for (int i = 1; i < NV; i++) offs[i] = 8'($urandom);

        rst = 1'b1; usb_tx_start = 1'b0; q = 8'd0; last_byte = 1'b0; ft_txe_n = 1'b1;
        prev_hold = 1'b0; prev_data = 8'd0; txe_mode = 0; b2b = 1'b0; fin_cnt = -1;
        cur_n = 0; cur_off = 8'd0; acc_idx = 0; fd_cnt = 0; sw_cnt = 0;
        stall_left = 0; stall_done = 1'b0; nxt_n = 0; nxt_off = 8'd0;
        reader_init(FRAME, 8'd0);
        #1;
        reset_vals("rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        started = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].b2b && (i + 1 < NV)) begin
                nxt_n = tbl[i + 1].n_bytes;
                nxt_off = offs[i + 1];
            end
            run_frame(tbl[i], offs[i], started);
            started = tbl[i].b2b;
        end

        reset_mid_frame();

        for (int k = 0; k < 20; k++) begin
            n = $urandom_range(2, 40);
            v.n_bytes = n;
            v.txe_mode = 3;
            v.b2b = 1'b0;
            v.exp_cnt = (n > 31) ? 31 : n;
            v.exp_len_err = (v.exp_cnt != FRAME);
            run_frame(v, 8'($urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
